adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe_if.sv | 26 ++
 rtl/adder_pipe.sv | 88 ++++++++
 tb/tb_adder_pipe.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// Handshake bundle for adder_pipe: operand input channel plus result output channel.
interface adder_pipe_if #(
  parameter int WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             mode;
  logic             clear_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [15:0]      txn_count;

  modport master (
    output in_valid, A, B, mode, clear_acc, out_ready,
    input  in_ready, out_valid, sum, carry, txn_count
  );

  modport slave (
    input  in_valid, A, B, mode, clear_acc, out_ready,
    output in_ready, out_valid, sum, carry, txn_count
  );
endinterface

// File: rtl/adder_pipe.sv
// Two-stage valid/ready adder with wrap or saturate and an accumulate mode.
// Latency 2 cycles; a stalled output freezes S2 and S1, and in_ready drops once S1 is occupied.
module adder_pipe #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);

  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  logic             out_vld_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc;
  logic [15:0]      cnt;

  logic             adv;
  logic             s2_load;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] sum_nxt;

  assign adv          = !out_vld_q || bus.out_ready;
  assign s2_load      = adv && s1_vld;
  assign bus.in_ready = !s1_vld || adv;

  // A clear coinciding with an accumulate load zeroes that operation's Y.
  always_comb begin
    y = s1_b;
    if (s1_mode) begin
      y = bus.clear_acc ? '0 : acc;
    end
    full    = {1'b0, s1_a} + {1'b0, y};
    sum_nxt = full[WIDTH-1:0];
    if (SATURATE && full[WIDTH]) begin
      sum_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= 1'b0;
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_vld <= bus.in_valid;
      end
      if (bus.in_valid && bus.in_ready) begin
        s1_a    <= bus.A;
        s1_b    <= bus.B;
        s1_mode <= bus.mode;
      end
      if (adv) begin
        out_vld_q <= s1_vld;
      end
      if (s2_load) begin
        sum_q   <= sum_nxt;
        carry_q <= full[WIDTH];
      end
      if (s2_load && s1_mode) begin
        acc <= sum_nxt;
      end else if (bus.clear_acc) begin
        acc <= '0;
      end
      if (out_vld_q && bus.out_ready) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.txn_count = cnt;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench: one wrapping and one saturating adder_pipe driven with identical stimulus.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       clear_acc = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;

  adder_pipe_if #(.WIDTH(4)) b0 ();
  adder_pipe_if #(.WIDTH(4)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.A         = a_in;
  assign b0.B         = b_in;
  assign b0.mode      = mode;
  assign b0.clear_acc = clear_acc;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.A         = a_in;
  assign b1.B         = b_in;
  assign b1.mode      = mode;
  assign b1.clear_acc = clear_acc;
  assign b1.out_ready = out_ready;

  adder_pipe #(.WIDTH(4), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  adder_pipe #(.WIDTH(4), .SATURATE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct packed {
    logic [3:0] sum;
    logic       carry;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] acc0 = '0;
  logic [3:0] acc1 = '0;
  int         exp_cnt = 0;
  logic       mon_en = 1'b0;
  logic       stall_prev [2];
  logic [3:0] sum_prev [2];
  logic       car_prev [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted operation in order, plain integer arithmetic.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic m, input logic zy);
    int   s0, s1;
    exp_t e0, e1;
    s0 = int'(a) + (m ? (zy ? 0 : int'(acc0)) : int'(b));
    s1 = int'(a) + (m ? (zy ? 0 : int'(acc1)) : int'(b));
    e0.carry = (s0 > 15);
    e0.sum   = 4'(s0 % 16);
    e1.carry = (s1 > 15);
    e1.sum   = e1.carry ? 4'hF : 4'(s1 % 16);
    if (m) begin
      acc0 = e0.sum;
      acc1 = e1.sum;
    end
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic cyc(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m,
                     input logic zy, input logic clr, input logic ordy, output logic fire);
    @(posedge clk);
    #1;
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    mode      = m;
    clear_acc = clr;
    out_ready = ordy;
    @(negedge clk);
    fire = v && b0.in_ready;
    if (fire) push(a, b, m, zy);
  endtask

  task automatic idle(input int n);
    logic f;
    repeat (n) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    clear_acc = 1'b0;
    out_ready = 1'b1;
    q0.delete();
    q1.delete();
    acc0 = '0;
    acc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mon(input int d, input logic vld, input logic [3:0] s, input logic c);
    exp_t e;
    if (stall_prev[d]) begin
      chk("hold_valid", int'(vld), 1);
      chk("hold_sum", int'(s), int'(sum_prev[d]));
      chk("hold_carry", int'(c), int'(car_prev[d]));
    end
    if (vld && out_ready) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: dut%0d sum %0d with empty scoreboard", d, s);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk((d == 0) ? "sum_wrap" : "sum_sat", int'(s), int'(e.sum));
        chk((d == 0) ? "carry_wrap" : "carry_sat", int'(c), int'(e.carry));
      end
    end
    stall_prev[d] = vld && !out_ready;
    sum_prev[d]   = s;
    car_prev[d]   = c;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("txn_count", int'(b0.txn_count), exp_cnt);
      chk("txn_count_sat", int'(b1.txn_count), exp_cnt);
      if (rst) begin
        exp_cnt       = 0;
        stall_prev[0] = 1'b0;
        stall_prev[1] = 1'b0;
      end else begin
        mon(0, b0.out_valid, b0.sum, b0.carry);
        mon(1, b1.out_valid, b1.sum, b1.carry);
        if (b0.out_valid && out_ready) exp_cnt = (exp_cnt + 1) % 65536;
      end
    end
  end

  initial begin
    logic f;
    int   k;
    logic [3:0] ops [3];
    stall_prev[0] = 1'b0;
    stall_prev[1] = 1'b0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", int'(b0.out_valid), 0);
    chk("reset_in_ready", int'(b0.in_ready), 1);

    // Wrap and carry, two-cycle latency
    cyc(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, f);
    chk("accept_first", int'(f), 1);
    cyc(1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, f);
    chk("latency_not_early", int'(b0.out_valid), 0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, f);
    chk("latency_two", int'(b0.out_valid), 1);
    idle(3);
    chk("txn_after_two", int'(b0.txn_count), 2);
    chk("bubble_out_valid", int'(b0.out_valid), 0);

    // Saturation case
    cyc(1'b1, 4'hC, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, f);
    idle(3);

    // Back-to-back accumulate, then read acc back with A=0
    cyc(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    cyc(1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    cyc(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    cyc(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    idle(4);

    // Idle clear, load 9, then clear coinciding with the A=3 accumulate
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, f);
    acc0 = '0;
    acc1 = '0;
    cyc(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    idle(3);
    cyc(1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, f);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, f);
    idle(2);
    cyc(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    idle(3);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, f);
    acc0 = '0;
    acc1 = '0;
    cyc(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    idle(3);

    // Backpressure: three offered over four stalled cycles
    ops[0] = 4'd1;
    ops[1] = 4'd2;
    ops[2] = 4'd3;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, ops[k], 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, f);
      if (f) k++;
    end
    chk("stall_accepted", k, 2);
    chk("stall_in_ready", int'(b0.in_ready), 0);
    chk("stall_out_valid", int'(b0.out_valid), 1);
    idle(4);
    chk("stall_drained", q0.size() + q1.size(), 0);

    // Reset with both stages full
    cyc(1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, f);
    cyc(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, f);
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", int'(b0.out_valid), 0);
    chk("rst_in_ready", int'(b0.in_ready), 1);
    chk("rst_txn_count", int'(b0.txn_count), 0);
    cyc(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, f);
    idle(3);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
          1'b0, 1'b0, ($urandom % 4) != 0, f);
    end
    idle(6);
    chk("random_drained", q0.size() + q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
